// File: rtl/mc14500_seq.sv
// mc14500_seq: program sequencer and I/O bus controller for an MC14500 1-bit ICU.
// Ports: clk/rst (sync, active-high), run start pulse, rom_addr/rom_data program ROM
// (1-cycle read), icu_i/icu_write/icu_d_out/icu_d_in ICU bus, in_bits/out_bits I/O, halted, stk_err.
// Latency: 1 cycle from run to first instruction in E; taken JMP/call/RTN costs one bubble.
// Backpressure: none; the ICU consumes one instruction per cycle while running.
module mc14500_seq #(
  parameter int PCW   = 8,
  parameter int IOW   = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [PCW-1:0]     rom_addr,
  input  logic [PCW+3:0]     rom_data,
  output logic [3:0]         icu_i,
  input  logic               icu_write,
  input  logic               icu_d_out,
  output logic               icu_d_in,
  input  logic [2**IOW-1:0]  in_bits,
  output logic [2**IOW-1:0]  out_bits,
  output logic               halted,
  output logic               stk_err
);

  localparam int SPW = $clog2(DEPTH) + 1;

  localparam logic [3:0] OP_NOPO = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RTN  = 4'b1101;
  localparam logic [3:0] OP_NOPF = 4'b1111;

  typedef enum logic {S_HALT, S_RUN} state_t;

  state_t           state, state_nx;
  logic [PCW-1:0]   pc, pc_nx;
  logic [PCW-1:0]   e_pc, e_pc_nx;
  logic             e_valid, e_valid_nx;
  logic [SPW-1:0]   sp, sp_nx;
  logic             push;
  logic             err_set;
  logic [PCW-1:0]   stack [DEPTH];

  logic [3:0]       opcode;
  logic [PCW-1:0]   operand;
  logic [IOW-1:0]   io_sel;
  logic [PCW-1:0]   pc_inc;
  logic [PCW-1:0]   ret_addr;
  logic [SPW-1:0]   sp_dec;

  assign opcode   = rom_data[PCW+3:PCW];
  assign operand  = rom_data[PCW-1:0];
  assign io_sel   = operand[IOW-1:0];
  assign pc_inc   = pc + PCW'(1);
  // Return address wraps the same way the pc does.
  assign ret_addr = e_pc + PCW'(1);
  assign sp_dec   = sp - SPW'(1);

  assign rom_addr = pc;
  assign icu_i    = e_valid ? opcode : OP_NOPO;
  assign icu_d_in = in_bits[io_sel];
  assign halted   = (state == S_HALT);

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    e_pc_nx    = e_pc;
    e_valid_nx = 1'b0;
    sp_nx      = sp;
    push       = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_HALT: begin
        if (run) begin
          pc_nx      = pc_inc;
          e_pc_nx    = pc;
          e_valid_nx = 1'b1;
          state_nx   = S_RUN;
        end
      end
      S_RUN: begin
        pc_nx      = pc_inc;
        e_pc_nx    = pc;
        e_valid_nx = 1'b1;
        // Any transfer squashes the word fetched behind it; halts resume at e_pc+1.
        if (e_valid) begin
          case (opcode)
            OP_JMP: begin
              pc_nx      = operand;
              e_valid_nx = 1'b0;
            end
            OP_NOPF: begin
              e_valid_nx = 1'b0;
              if (sp < SPW'(DEPTH)) begin
                push  = 1'b1;
                sp_nx = sp + SPW'(1);
                pc_nx = operand;
              end else begin
                err_set  = 1'b1;
                state_nx = S_HALT;
                pc_nx    = ret_addr;
              end
            end
            OP_RTN: begin
              e_valid_nx = 1'b0;
              if (sp != '0) begin
                sp_nx = sp_dec;
                pc_nx = stack[sp_dec[SPW-2:0]];
              end else begin
                err_set  = 1'b1;
                state_nx = S_HALT;
                pc_nx    = ret_addr;
              end
            end
            OP_NOPO: begin
              e_valid_nx = 1'b0;
              state_nx   = S_HALT;
              pc_nx      = ret_addr;
            end
            default: ;
          endcase
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HALT;
      pc       <= '0;
      e_pc     <= '0;
      e_valid  <= 1'b0;
      sp       <= '0;
      stk_err  <= 1'b0;
      out_bits <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      e_pc    <= e_pc_nx;
      e_valid <= e_valid_nx;
      sp      <= sp_nx;
      if (err_set) stk_err <= 1'b1;
      if (e_valid && icu_write) out_bits[io_sel] <= icu_d_out;
    end
  end

  // Stack storage needs no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack[sp[SPW-2:0]] <= ret_addr;
  end

endmodule

// File: tb/tb_mc14500_seq.sv
module tb_mc14500_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  icu_i;
  logic        icu_write;
  logic        icu_d_out;
  logic        icu_d_in;
  logic [15:0] in_bits;
  logic [15:0] out_bits;
  logic        halted;
  logic        stk_err;

  logic [11:0] rom [256];
  logic        rr;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mc14500_seq #(.PCW(8), .IOW(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .icu_i(icu_i), .icu_write(icu_write), .icu_d_out(icu_d_out), .icu_d_in(icu_d_in),
    .in_bits(in_bits), .out_bits(out_bits),
    .halted(halted), .stk_err(stk_err)
  );

  // Synchronous program ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Minimal ICU: LD loads the result register, STO/STOC drive the data bus.
  always @(posedge clk) begin
    if (rst) rr <= 1'b0;
    else if (icu_i == 4'b0001) rr <= icu_d_in;
  end
  assign icu_write = (icu_i == 4'b1000) || (icu_i == 4'b1001);
  assign icu_d_out = (icu_i == 4'b1001) ? ~rr : rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    in_bits = 16'h0008;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    rom[8'h00] = 12'h103;  // LD 3
    rom[8'h01] = 12'h805;  // STO 5
    rom[8'h02] = 12'hC40;  // JMP 0x40
    rom[8'h03] = 12'h806;  // STO 6, must be squashed
    rom[8'h40] = 12'hC10;  // JMP 0x10
    rom[8'h10] = 12'hF80;  // call 0x80
    rom[8'h80] = 12'hD00;  // RTN
    rom[8'h11] = 12'hC20;  // JMP 0x20
    rom[8'h20] = 12'h000;  // halt
    rom[8'h21] = 12'hCFF;  // JMP 0xFF
    rom[8'hFF] = 12'h400;  // OR 0, falls through to 0x00

    repeat (3) step();
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_addr", 32'(rom_addr), 32'h00);
    chk("rst_icu_i", 32'(icu_i), 32'h0);
    chk("rst_out", 32'(out_bits), 32'h0000);
    chk("rst_stk_err", 32'(stk_err), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_addr", 32'(rom_addr), 32'h00);
    chk("idle_halted", 32'(halted), 32'd1);

    run = 1'b1;
    step();
    run = 1'b0;
    chk("start_halted", 32'(halted), 32'd0);
    chk("start_addr", 32'(rom_addr), 32'h01);
    chk("start_icu_i", 32'(icu_i), 32'h1);
    chk("start_d_in", 32'(icu_d_in), 32'd1);
    step();
    chk("sto_addr", 32'(rom_addr), 32'h02);
    chk("sto_icu_i", 32'(icu_i), 32'h8);
    chk("sto_pre_out", 32'(out_bits), 32'h0000);
    step();
    chk("sto_out", 32'(out_bits), 32'h0020);
    chk("jmp_icu_i", 32'(icu_i), 32'hC);
    step();
    chk("jmp_bubble", 32'(icu_i), 32'h0);
    chk("jmp_addr", 32'(rom_addr), 32'h40);
    step();
    chk("jmp_tgt_icu_i", 32'(icu_i), 32'hC);
    chk("jmp_tgt_addr", 32'(rom_addr), 32'h41);
    chk("squash_out", 32'(out_bits), 32'h0020);
    step();
    chk("jmp2_addr", 32'(rom_addr), 32'h10);
    step();
    chk("call_icu_i", 32'(icu_i), 32'hF);
    step();
    chk("call_addr", 32'(rom_addr), 32'h80);
    chk("call_sp", 32'(dut.sp), 32'd1);
    chk("call_bubble", 32'(icu_i), 32'h0);
    step();
    chk("rtn_icu_i", 32'(icu_i), 32'hD);
    step();
    chk("rtn_addr", 32'(rom_addr), 32'h11);
    chk("rtn_sp", 32'(dut.sp), 32'd0);
    step();
    chk("ret_icu_i", 32'(icu_i), 32'hC);
    chk("ret_addr_next", 32'(rom_addr), 32'h12);
    step();
    chk("jmp3_addr", 32'(rom_addr), 32'h20);
    step();
    chk("halt_icu_i", 32'(icu_i), 32'h0);
    chk("halt_pre", 32'(halted), 32'd0);
    step();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc", 32'(rom_addr), 32'h21);
    step();
    chk("halt_hold_pc", 32'(rom_addr), 32'h21);
    chk("halt_hold", 32'(halted), 32'd1);

    run = 1'b1;
    step();
    run = 1'b0;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_icu_i", 32'(icu_i), 32'hC);
    chk("resume_addr", 32'(rom_addr), 32'h22);
    step();
    chk("to_ff_addr", 32'(rom_addr), 32'hFF);
    step();
    chk("wrap_addr", 32'(rom_addr), 32'h00);
    chk("ff_icu_i", 32'(icu_i), 32'h4);
    step();
    chk("wrap_e_icu_i", 32'(icu_i), 32'h1);
    chk("wrap_next_addr", 32'(rom_addr), 32'h01);
    chk("pre_rst_out", 32'(out_bits), 32'h0020);

    rst = 1'b1;
    run = 1'b1;
    step();
    chk("midrst_halted", 32'(halted), 32'd1);
    chk("midrst_addr", 32'(rom_addr), 32'h00);
    chk("midrst_out", 32'(out_bits), 32'h0000);
    chk("midrst_icu_i", 32'(icu_i), 32'h0);
    step();
    chk("rst_over_run", 32'(halted), 32'd1);
    rst = 1'b0;
    run = 1'b0;

    // Stack overflow: DEPTH+1 nested calls starting at 0x30.
    rom[8'h00] = 12'hC30;
    for (int k = 0; k < 5; k++) rom[8'h30 + k] = 12'hF31 + 12'(k);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("ovf_start_err", 32'(stk_err), 32'd0);
    chk("ovf_start_icu_i", 32'(icu_i), 32'hC);
    for (int i = 0; i < 40 && !halted; i++) step();
    chk("ovf_halted", 32'(halted), 32'd1);
    chk("ovf_err", 32'(stk_err), 32'd1);
    chk("ovf_pc", 32'(rom_addr), 32'h35);
    chk("ovf_sp", 32'(dut.sp), 32'd4);
    repeat (2) step();
    chk("ovf_sticky", 32'(stk_err), 32'd1);

    // Stack underflow: RTN with an empty stack.
    rst = 1'b1;
    step();
    chk("err_cleared", 32'(stk_err), 32'd0);
    rst = 1'b0;
    rom[8'h00] = 12'hD00;
    run = 1'b1;
    step();
    run = 1'b0;
    chk("unf_icu_i", 32'(icu_i), 32'hD);
    step();
    chk("unf_halted", 32'(halted), 32'd1);
    chk("unf_err", 32'(stk_err), 32'd1);
    chk("unf_pc", 32'(rom_addr), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
